// File: rtl/jelly3_axi4s_pkg.sv
// Shared types for the jelly3 AXI4-Stream packet buffer.
// Beat layout in RAM is {tuser, tlast, tdata}.
package jelly3_axi4s_pkg;

  typedef enum logic {
    FILL,
    DROP
  } state_t;

  function automatic int beat_bits(
    input int data_bits,
    input int user_bits
  );
    return data_bits + user_bits + 1;
  endfunction

endpackage

// File: rtl/jelly3_axi4s_packet_buffer_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// The read register holds its value while rd_en_i is low.
module jelly3_axi4s_packet_buffer_ram #(
  parameter int    ADDR_BITS = 9,
  parameter int    DATA_BITS = 34,
  parameter string RAM_TYPE  = "block"
) (
  input  logic                 clk_i,
  input  logic                 wr_en_i,
  input  logic [ADDR_BITS-1:0] wr_addr_i,
  input  logic [DATA_BITS-1:0] wr_data_i,
  input  logic                 rd_en_i,
  input  logic [ADDR_BITS-1:0] rd_addr_i,
  output logic [DATA_BITS-1:0] rd_data_o
);

  (* ram_style = RAM_TYPE *)
  logic [DATA_BITS-1:0] mem_q [2**ADDR_BITS];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_o <= mem_q[rd_addr_i];
  end

endmodule

// File: rtl/jelly3_axi4s_packet_buffer.sv
// Store-and-forward AXI4-Stream packet buffer.
// Packets are released downstream only once their tlast beat is stored.
module jelly3_axi4s_packet_buffer
  import jelly3_axi4s_pkg::*;
#(
  parameter int    DATA_BITS = 32,
  parameter int    USER_BITS = 1,
  parameter int    PTR_BITS  = 9,
  parameter string RAM_TYPE  = "block"
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] s_tdata,
  input  logic [USER_BITS-1:0] s_tuser,
  input  logic                 s_tlast,
  input  logic                 s_tvalid,
  output logic                 s_tready,
  output logic [DATA_BITS-1:0] m_tdata,
  output logic [USER_BITS-1:0] m_tuser,
  output logic                 m_tlast,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic [PTR_BITS:0]    packet_count,
  output logic [PTR_BITS:0]    data_count,
  output logic [15:0]          drop_count
);

  localparam int BEAT_BITS = beat_bits(DATA_BITS, USER_BITS);

  typedef logic [PTR_BITS:0] ptr_t;
  localparam ptr_t DEPTH = ptr_t'(2**PTR_BITS);
  localparam ptr_t ONE   = ptr_t'(1);

  state_t state_q, state_d;
  ptr_t   wr_ptr_q, wr_ptr_d;
  ptr_t   cm_ptr_q, cm_ptr_d;
  ptr_t   fe_ptr_q, fe_ptr_d;
  ptr_t   rd_ptr_q, rd_ptr_d;
  ptr_t   pkt_q, pkt_d;
  logic [15:0] drop_q, drop_d;
  logic   ram_vld_q, ram_vld_d;
  logic   out_vld_q, out_vld_d;
  logic [BEAT_BITS-1:0] out_q, out_d;

  logic s_ready;
  logic full, over;
  logic wr_en, pkt_inc, pkt_dec;
  logic avail, m_hs, load_out, rd_en;
  logic [BEAT_BITS-1:0] rd_data;

  jelly3_axi4s_packet_buffer_ram #(
    .ADDR_BITS(PTR_BITS),
    .DATA_BITS(BEAT_BITS),
    .RAM_TYPE (RAM_TYPE)
  ) u_ram (
    .clk_i    (clk),
    .wr_en_i  (wr_en),
    .wr_addr_i(wr_ptr_q[PTR_BITS-1:0]),
    .wr_data_i({s_tuser, s_tlast, s_tdata}),
    .rd_en_i  (rd_en),
    .rd_addr_i(fe_ptr_q[PTR_BITS-1:0]),
    .rd_data_o(rd_data)
  );

  // over: the in-progress packet alone fills the whole buffer
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    cm_ptr_d = cm_ptr_q;
    drop_d   = drop_q;
    s_ready  = 1'b0;
    wr_en    = 1'b0;
    pkt_inc  = 1'b0;
    full     = (wr_ptr_q - rd_ptr_q) == DEPTH;
    over     = (wr_ptr_q - cm_ptr_q) == DEPTH;
    unique case (state_q)
      FILL: begin
        s_ready = !full;
        if (s_tvalid && s_ready) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + ONE;
          if (s_tlast) begin
            cm_ptr_d = wr_ptr_q + ONE;
            pkt_inc  = 1'b1;
          end
        end else if (s_tvalid && over) begin
          state_d  = DROP;
          wr_ptr_d = cm_ptr_q;
        end
      end
      DROP: begin
        s_ready = 1'b1;
        if (s_tvalid && s_tlast) begin
          state_d = FILL;
          if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
        end
      end
    endcase
  end

  always_comb begin
    avail     = fe_ptr_q != cm_ptr_q;
    m_hs      = out_vld_q && m_tready;
    load_out  = ram_vld_q && (!out_vld_q || m_tready);
    rd_en     = avail && (!ram_vld_q || load_out);
    fe_ptr_d  = fe_ptr_q + ptr_t'(rd_en);
    rd_ptr_d  = rd_ptr_q + ptr_t'(m_hs);
    ram_vld_d = rd_en || (ram_vld_q && !load_out);
    out_vld_d = load_out || (out_vld_q && !m_tready);
    out_d     = load_out ? rd_data : out_q;
    pkt_dec   = m_hs && out_q[DATA_BITS];
    unique case ({pkt_inc, pkt_dec})
      2'b10:   pkt_d = pkt_q + ONE;
      2'b01:   pkt_d = pkt_q - ONE;
      default: pkt_d = pkt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FILL;
      wr_ptr_q  <= '0;
      cm_ptr_q  <= '0;
      fe_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      pkt_q     <= '0;
      drop_q    <= '0;
      ram_vld_q <= 1'b0;
      out_vld_q <= 1'b0;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      cm_ptr_q  <= cm_ptr_d;
      fe_ptr_q  <= fe_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      pkt_q     <= pkt_d;
      drop_q    <= drop_d;
      ram_vld_q <= ram_vld_d;
      out_vld_q <= out_vld_d;
      out_q     <= out_d;
    end
  end

  assign s_tready     = s_ready && !reset;
  assign m_tdata      = out_q[DATA_BITS-1:0];
  assign m_tlast      = out_q[DATA_BITS];
  assign m_tuser      = out_q[BEAT_BITS-1 -: USER_BITS];
  assign m_tvalid     = out_vld_q;
  assign packet_count = pkt_q;
  assign data_count   = wr_ptr_q - rd_ptr_q;
  assign drop_count   = drop_q;

endmodule

// File: tb/tb_jelly3_axi4s_packet_buffer.sv
// Bench for jelly3_axi4s_packet_buffer.
// Accepted beats of kept packets go to a queue; output beats pop it.
module tb_jelly3_axi4s_packet_buffer;

  logic        clk;
  logic        reset;
  logic [31:0] s_tdata;
  logic [0:0]  s_tuser;
  logic        s_tlast;
  logic        s_tvalid;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic [0:0]  m_tuser;
  logic        m_tlast;
  logic        m_tvalid;
  logic        m_tready;
  logic [9:0]  packet_count;
  logic [9:0]  data_count;
  logic [15:0] drop_count;

  int n_chk  = 0;
  int n_fail = 0;
  int rdy_mode = 0;
  logic [33:0] exp_q[$];

  jelly3_axi4s_packet_buffer #(
    .DATA_BITS(32),
    .USER_BITS(1),
    .PTR_BITS (9),
    .RAM_TYPE ("block")
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .s_tdata     (s_tdata),
    .s_tuser     (s_tuser),
    .s_tlast     (s_tlast),
    .s_tvalid    (s_tvalid),
    .s_tready    (s_tready),
    .m_tdata     (m_tdata),
    .m_tuser     (m_tuser),
    .m_tlast     (m_tlast),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .packet_count(packet_count),
    .data_count  (data_count),
    .drop_count  (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic u,
                           input logic l, input bit push, input int gap);
    bit acc;
    int n;
    if (gap > 0) begin
      s_tvalid = 1'b0;
      repeat (gap) tick();
    end
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tuser  = u;
    s_tlast  = l;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 5000) begin
      @(negedge clk);
      acc = s_tready;
      @(posedge clk);
      #1;
      n++;
    end
    check("s_accept", 64'(acc), 64'd1);
    if (acc && push) exp_q.push_back({u, l, d});
  endtask

  task automatic send_pkt(input int len, input logic [31:0] base,
                          input bit push, input bit rnd_gap);
    int gap;
    for (int i = 0; i < len; i++) begin
      gap = 0;
      if (rnd_gap && $urandom_range(0, 7) == 0) gap = $urandom_range(1, 3);
      send_beat(base + 32'(i), i[0], i == len - 1, push, gap);
    end
    s_tvalid = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (exp_q.size() == 0 && !m_tvalid) break;
      tick();
    end
    check("drain_left", 64'(exp_q.size()), 64'd0);
    check("drain_dcnt", 64'(data_count), 64'd0);
  endtask

  // Called just after the edge that accepted tlast.
  task automatic check_release(input int len);
    check("rel_n0", 64'(m_tvalid), 64'd0);
    tick();
    check("rel_n1", 64'(m_tvalid), 64'd0);
    tick();
    for (int i = 0; i < len; i++) begin
      check("rel_contig", 64'(m_tvalid), 64'd1);
      tick();
    end
    check("rel_end_vld", 64'(m_tvalid), 64'd0);
    check("rel_end_pcnt", 64'(packet_count), 64'd0);
  endtask

  task automatic monitor();
    logic [33:0] prev, cur, e;
    bit stall;
    stall = 1'b0;
    prev  = '0;
    forever begin
      @(negedge clk);
      cur = {m_tuser, m_tlast, m_tdata};
      if (reset) begin
        stall = 1'b0;
      end else begin
        if (stall) check("m_hold", {m_tvalid, cur}, {1'b1, prev});
        if (m_tvalid && m_tready) begin
          check("m_q_nonempty", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("m_beat", 64'(cur), 64'(e));
          end
        end
        stall = m_tvalid && !m_tready;
        prev  = cur;
      end
    end
  endtask

  task automatic ready_drv();
    forever begin
      @(posedge clk);
      #1;
      unique case (rdy_mode)
        1:       m_tready = 1'b1;
        2:       m_tready = $urandom_range(0, 3) != 0;
        default: m_tready = 1'b0;
      endcase
    end
  endtask

  initial begin
    bit seen;
    reset    = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tuser  = '0;
    s_tlast  = 1'b0;
    m_tready = 1'b0;
    fork
      monitor();
      ready_drv();
      begin
        #(10 * 95000);
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
      end
    join_none

    rdy_mode = 1;
    repeat (3) tick();
    check("rst_s_tready", 64'(s_tready), 64'd0);
    check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_m_beat", 64'({m_tuser, m_tlast, m_tdata}), 64'd0);
    check("rst_pcnt", 64'(packet_count), 64'd0);
    check("rst_dcnt", 64'(data_count), 64'd0);
    check("rst_drop", 64'(drop_count), 64'd0);
    reset = 1'b0;
    tick();

    // single 4-beat packet
    send_pkt(4, 32'h10, 1'b1, 1'b0);
    check("p4_pcnt", 64'(packet_count), 64'd1);
    check_release(4);

    // upstream gap before tlast
    for (int i = 0; i < 3; i++)
      send_beat(32'h20 + 32'(i), 1'b0, 1'b0, 1'b1, 0);
    s_tvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("gap_no_vld", 64'(m_tvalid), 64'd0);
    end
    send_beat(32'h23, 1'b1, 1'b1, 1'b1, 0);
    s_tvalid = 1'b0;
    check_release(4);

    // exactly DEPTH fits, DEPTH+1 is dropped
    send_pkt(512, 32'h1000, 1'b1, 1'b0);
    check("d512_drop", 64'(drop_count), 64'd0);
    wait_drain(2000);
    send_pkt(513, 32'h2000, 1'b0, 1'b0);
    check("d513_drop", 64'(drop_count), 64'd1);
    check("d513_pcnt", 64'(packet_count), 64'd0);
    check("d513_dcnt", 64'(data_count), 64'd0);
    send_pkt(8, 32'h3000, 1'b1, 1'b0);
    wait_drain(200);

    // back-pressure from committed data, no drop
    rdy_mode = 0;
    tick();
    fork
      for (int p = 0; p < 6; p++)
        send_pkt(100, 32'h10000 * (p + 1), 1'b1, 1'b0);
      begin
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
          @(negedge clk);
          seen = data_count == 10'd512;
        end
        check("bp_full_seen", 64'(seen), 64'd1);
        check("bp_s_tready", 64'(s_tready), 64'd0);
        check("bp_pcnt", 64'(packet_count), 64'd5);
        repeat (10) tick();
        check("bp_hold_dcnt", 64'(data_count), 64'd512);
        check("bp_drop", 64'(drop_count), 64'd1);
        rdy_mode = 1;
      end
    join
    wait_drain(3000);

    // random valid/ready on both sides
    rdy_mode = 2;
    for (int p = 0; p < 1000; p++)
      send_pkt($urandom_range(1, 64), $urandom, 1'b1, 1'b1);
    rdy_mode = 1;
    wait_drain(5000);
    check("rnd_drop", 64'(drop_count), 64'd1);
    check("rnd_pcnt", 64'(packet_count), 64'd0);

    // reset mid-packet with two stored packets
    rdy_mode = 0;
    tick();
    send_pkt(5, 32'h500, 1'b0, 1'b0);
    send_pkt(5, 32'h510, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      send_beat(32'h520 + 32'(i), 1'b0, 1'b0, 1'b0, 0);
    s_tvalid = 1'b0;
    check("mr_pcnt", 64'(packet_count), 64'd2);
    check("mr_dcnt", 64'(data_count), 64'd13);
    reset = 1'b1;
    tick();
    check("mr_m_tvalid", 64'(m_tvalid), 64'd0);
    check("mr_pcnt0", 64'(packet_count), 64'd0);
    check("mr_dcnt0", 64'(data_count), 64'd0);
    check("mr_drop0", 64'(drop_count), 64'd0);
    reset = 1'b0;
    rdy_mode = 1;
    tick();
    tick();
    send_pkt(6, 32'h600, 1'b1, 1'b0);
    check_release(6);
    check("mr_q_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/jelly3_axi4s_packet_buffer.md
Name: jelly3_axi4s_packet_buffer

Overview:
- Store-and-forward packet buffer on the receiving (slave) end of an AXI4-Stream link.
- Accepts beats, but releases a packet on the master side only after its tlast beat has been stored.
- Downstream consumers therefore never see a partial packet or stall mid-packet because of an upstream gap.
- Packets longer than the buffer are dropped whole and counted.

Parameters:
- DATA_BITS, 32, tdata width.
- USER_BITS, 1, tuser width; stored per beat.
- PTR_BITS, 9, log2 of buffer depth in beats (DEPTH = 2**PTR_BITS).
- RAM_TYPE, "block", RAM style attribute passed to the RAM sub-module.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high.
- s_tdata  input  DATA_BITS  upstream data.
- s_tuser  input  USER_BITS  upstream user.
- s_tlast  input  1  upstream end-of-packet.
- s_tvalid  input  1  upstream valid.
- s_tready  output  1  upstream ready.
- m_tdata  output  DATA_BITS  downstream data.
- m_tuser  output  USER_BITS  downstream user.
- m_tlast  output  1  downstream end-of-packet.
- m_tvalid  output  1  downstream valid.
- m_tready  input  1  downstream ready.
- packet_count  output  PTR_BITS+1  complete packets currently stored.
- data_count  output  PTR_BITS+1  beats stored, committed plus in-progress.
- drop_count  output  16  packets dropped for oversize; saturates at 0xFFFF.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset). All state updates on the rising edge of clk.
- Reset values: s_tready=0, m_tvalid=0, m_tdata/m_tuser/m_tlast=0, all counters=0, all pointers=0. Write FSM enters FILL.
- Pointers are PTR_BITS+1 wide with natural wrap-around: wr_ptr (speculative write), cm_ptr (committed), rd_ptr (read).
- Full condition: (wr_ptr - rd_ptr) == DEPTH.
- Write FSM states:
  - FILL:
    - s_tready = !full.
    - Each s handshake writes {tuser, tlast, tdata} at wr_ptr and increments wr_ptr.
    - A tlast handshake sets cm_ptr <= wr_ptr+1 on the same edge and increments packet_count.
    - If (wr_ptr - cm_ptr) == DEPTH while a non-tlast beat is pending, the packet can never fit: go to DROP and set wr_ptr <= cm_ptr.
  - DROP:
    - s_tready = 1; beats are discarded.
    - On the tlast handshake: drop_count++ (saturating), return to FILL.
- Back-pressure versus drop:
  - full caused by committed data → back-pressure only, never drop.
  - A packet of exactly DEPTH beats fits and is not dropped.
- Read side:
  - Committed data available when rd_ptr != cm_ptr.
  - RAM read latency is 1 cycle, followed by a single output register.
  - Standard AXI4-Stream: m_tvalid held with stable m_tdata/m_tuser/m_tlast until m_tready.
  - Zero-bubble streaming of consecutive committed beats when m_tready stays 1.
- packet_count decrements on an m handshake with m_tlast=1. A simultaneous increment and decrement leaves it unchanged.
- Latency: with the buffer empty and m_tready=1, if a tlast beat is accepted at edge N, the first beat of that packet is visible with m_tvalid=1 after edge N+2.
- data_count = wr_ptr - rd_ptr (registered) and includes the output-register beat.
- Reset mid-operation discards all stored and in-progress packets. No protocol violation is emitted because m_tvalid goes to 0 synchronously.
- Known limitation: a packet with no tlast holds the buffer indefinitely.

Decomposition:
- jelly3_axi4s_pkg: typedef state_t {FILL, DROP}; localparam helper for the packed beat width (DATA_BITS + USER_BITS + 1).
- Sub-module jelly3_axi4s_packet_buffer_ram: simple dual-port RAM, one write port and one registered read port, RAM_TYPE attribute. The main module holds the FSM, pointers, counters and output register.
- The main module is instantiable behind the existing jelly3_axi4s_if s/m modports via a thin wrapper. Simulation assertions on those interfaces apply to its ports.

Test Plan:
- Single 4-beat packet (tdata 0x10..0x13), m_tready=1 → m_tvalid rises 2 cycles after the tlast beat; beats emerge in order with tlast on 0x13; packet_count goes 1→0.
- Upstream gap: 3 beats, 5 idle cycles, tlast beat → m_tvalid stays 0 until 2 cycles after tlast; output is contiguous with no bubbles.
- DEPTH=512, exactly 512-beat packet → accepted, output intact, drop_count=0; a 513-beat packet → dropped, drop_count=1, next 8-beat packet passes intact.
- m_tready=0 while 600 beats of 100-beat packets arrive → s_tready falls when data_count=512, no drop; releasing m_tready drains all packets in order.
- Random valid/ready toggling on both sides, 1000 packets of length 1..64 → output matches a scoreboard exactly; m_tdata stable whenever m_tvalid && !m_tready.
- Reset asserted mid-packet with 2 stored packets → next cycle m_tvalid=0, all counters 0; a subsequent packet passes normally.
